rx_ctrl_fsm: RTL and testbench

//  USB receive-side control unit. Sequences the bit/byte counter pair
//  (drives cnt_up/clear/pause, consumes bit_rcvd/byte_rcvd) and validates SYNC.

---
 rtl/rx_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_rx_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl_fsm.sv
// USB receive control: sequences the bit/byte counters, validates SYNC, strobes
// each data byte into the RX FIFO and flags SYNC, framing and overflow errors.
module rx_ctrl_fsm #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic [7:0] rcv_data,
    input  logic       bit_rcvd,
    input  logic       byte_rcvd,
    output logic       cnt_up,
    output logic       cnt_clear,
    output logic       cnt_pause,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic       blk_rdy,
    output logic [7:0] byte_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC_RX,
        CHK_SYNC,
        DATA_RX,
        STORE,
        EOP_WAIT,
        ERR_WAIT
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

    state_t     state, next_state;
    logic       bit_rcvd_q, byte_rcvd_q;
    logic       mid_byte;
    logic       byte_evt, blk_evt, eop_bit;
    logic [7:0] byte_cnt_inc;

    assign byte_evt     = bit_rcvd & ~bit_rcvd_q;
    assign blk_evt      = byte_rcvd & ~byte_rcvd_q;
    assign eop_bit      = eop & shift_enable;
    assign byte_cnt_inc = byte_cnt + 8'd1;

    assign cnt_up    = shift_enable & ~eop & ((state == SYNC_RX) || (state == DATA_RX));
    assign cnt_clear = (state == IDLE);
    assign cnt_pause = (state == SYNC_RX);
    assign w_enable  = (state == STORE);
    assign rcving    = (state == SYNC_RX) || (state == CHK_SYNC) || (state == DATA_RX) ||
                       (state == STORE)   || (state == EOP_WAIT);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            bit_rcvd_q  <= 1'b0;
            byte_rcvd_q <= 1'b0;
            mid_byte    <= 1'b0;
            r_error     <= 1'b0;
            blk_rdy     <= 1'b0;
            byte_cnt    <= 8'd0;
        end else begin
            state       <= next_state;
            bit_rcvd_q  <= bit_rcvd;
            byte_rcvd_q <= byte_rcvd;
            blk_rdy     <= blk_evt & ((state == DATA_RX) || (state == STORE));

            // A bit sampled in the same cycle as a byte event belongs to the next byte.
            if (state == IDLE)
                mid_byte <= 1'b0;
            else if (cnt_up)
                mid_byte <= 1'b1;
            else if (byte_evt)
                mid_byte <= 1'b0;

            if ((state == IDLE) && d_edge)
                r_error <= 1'b0;
            else if (next_state == ERR_WAIT)
                r_error <= 1'b1;

            if ((state == IDLE) && d_edge)
                byte_cnt <= 8'd0;
            else if ((state == STORE) && (byte_cnt != MAX_CNT))
                byte_cnt <= byte_cnt_inc;
        end
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (d_edge) next_state = SYNC_RX;
            SYNC_RX: begin
                if (byte_evt)     next_state = CHK_SYNC;
                else if (eop_bit) next_state = ERR_WAIT;
            end
            CHK_SYNC: next_state = (rcv_data == SYNC_BYTE) ? DATA_RX : ERR_WAIT;
            DATA_RX: begin
                if (byte_evt)     next_state = STORE;
                else if (eop_bit) next_state = mid_byte ? ERR_WAIT : EOP_WAIT;
            end
            STORE:    next_state = (byte_cnt_inc == MAX_CNT) ? ERR_WAIT : DATA_RX;
            EOP_WAIT: if (d_edge && !eop) next_state = IDLE;
            ERR_WAIT: if (d_edge && !eop) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Directed bench for rx_ctrl_fsm: a default instance (MAX_BYTES=64) and a
// small instance (MAX_BYTES=4) share one stimulus stream.
module tb_rx_ctrl_fsm;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       bit_rcvd = 1'b0, byte_rcvd = 1'b0;

    logic       cnt_up, cnt_clear, cnt_pause, rcving, w_enable, r_error, blk_rdy;
    logic [7:0] byte_cnt;
    logic       cnt_up_s, cnt_clear_s, cnt_pause_s, rcving_s, w_enable_s, r_error_s, blk_rdy_s;
    logic [7:0] byte_cnt_s;

    int checks = 0;
    int errors = 0;
    int w_total = 0, w_total_s = 0, blk_total = 0;
    int w_base, w_base_s, blk_base;

    always #5 clk = ~clk;

    rx_ctrl_fsm u_dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .rcv_data(rcv_data),
        .bit_rcvd(bit_rcvd), .byte_rcvd(byte_rcvd),
        .cnt_up(cnt_up), .cnt_clear(cnt_clear), .cnt_pause(cnt_pause),
        .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
        .blk_rdy(blk_rdy), .byte_cnt(byte_cnt)
    );

    rx_ctrl_fsm #(.SYNC_BYTE(8'h80), .MAX_BYTES(4)) u_small (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .rcv_data(rcv_data),
        .bit_rcvd(bit_rcvd), .byte_rcvd(byte_rcvd),
        .cnt_up(cnt_up_s), .cnt_clear(cnt_clear_s), .cnt_pause(cnt_pause_s),
        .rcving(rcving_s), .w_enable(w_enable_s), .r_error(r_error_s),
        .blk_rdy(blk_rdy_s), .byte_cnt(byte_cnt_s)
    );

    // Strobe counters sample pre-edge values; the stimulus reads them at negedge.
    always @(posedge clk) begin
        if (w_enable)   w_total   = w_total + 1;
        if (w_enable_s) w_total_s = w_total_s + 1;
        if (blk_rdy)    blk_total = blk_total + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic snap();
        w_base   = w_total;
        w_base_s = w_total_s;
        blk_base = blk_total;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
            tick();
            tick();
        end
    endtask

    // bit_rcvd is held two cycles to exercise the rising-edge detection.
    task automatic send_byte(input logic [7:0] data, input logic blk);
        send_bits(8);
        rcv_data  = data;
        bit_rcvd  = 1'b1;
        byte_rcvd = blk;
        tick();
        tick();
        bit_rcvd  = 1'b0;
        byte_rcvd = 1'b0;
        tick();
    endtask

    task automatic start_packet();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
    endtask

    task automatic end_packet();
        eop = 1'b1;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        tick();
        eop = 1'b0;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_cnt_clear", {7'd0, cnt_clear}, 8'd1);
        check("rst_rcving",    {7'd0, rcving},    8'd0);
        check("rst_r_error",   {7'd0, r_error},   8'd0);
        check("rst_w_enable",  {7'd0, w_enable},  8'd0);
        check("rst_blk_rdy",   {7'd0, blk_rdy},   8'd0);
        check("rst_cnt_up",    {7'd0, cnt_up},    8'd0);
        check("rst_cnt_pause", {7'd0, cnt_pause}, 8'd0);
        check("rst_byte_cnt",  byte_cnt,          8'd0);
        n_rst = 1'b1;
        tick();

        // Good packet: SYNC + three data bytes, EOP on a byte boundary.
        snap();
        start_packet();
        check("sync_rcving",    {7'd0, rcving},    8'd1);
        check("sync_cnt_pause", {7'd0, cnt_pause}, 8'd1);
        check("sync_cnt_clear", {7'd0, cnt_clear}, 8'd0);
        shift_enable = 1'b1;
        #1;
        check("sync_cnt_up", {7'd0, cnt_up}, 8'd1);
        tick();
        shift_enable = 1'b0;
        tick();
        tick();
        send_bits(7);
        rcv_data = 8'h80;
        bit_rcvd = 1'b1;
        tick();
        tick();
        bit_rcvd = 1'b0;
        tick();
        check("data_cnt_pause", {7'd0, cnt_pause}, 8'd0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("good_wen_count", 8'(w_total - w_base), 8'd3);
        check("good_byte_cnt",  byte_cnt, 8'd3);
        end_packet();
        check("good_idle",      {7'd0, cnt_clear}, 8'd1);
        check("good_rcving",    {7'd0, rcving},    8'd0);
        check("good_r_error",   {7'd0, r_error},   8'd0);
        check("good_blk_count", 8'(blk_total - blk_base), 8'd0);
        check("good_cnt_hold",  byte_cnt, 8'd3);

        // Bad SYNC byte.
        snap();
        start_packet();
        send_byte(8'h81, 1'b0);
        check("badsync_r_error", {7'd0, r_error}, 8'd1);
        check("badsync_rcving",  {7'd0, rcving},  8'd0);
        check("badsync_wen",     8'(w_total - w_base), 8'd0);
        end_packet();
        check("badsync_idle",    {7'd0, cnt_clear}, 8'd1);
        check("badsync_sticky",  {7'd0, r_error},   8'd1);
        start_packet();
        check("newpkt_r_error",  {7'd0, r_error}, 8'd0);
        check("newpkt_byte_cnt", byte_cnt, 8'd0);

        // Asynchronous reset in the middle of a data byte.
        send_byte(8'h80, 1'b0);
        send_bits(3);
        check("mid_rcving", {7'd0, rcving}, 8'd1);
        snap();
        n_rst = 1'b0;
        #1;
        check("arst_cnt_clear", {7'd0, cnt_clear}, 8'd1);
        check("arst_rcving",    {7'd0, rcving},    8'd0);
        check("arst_cnt_pause", {7'd0, cnt_pause}, 8'd0);
        check("arst_byte_cnt",  byte_cnt,          8'd0);
        tick();
        n_rst = 1'b1;
        tick();
        check("arst_idle",   {7'd0, cnt_clear}, 8'd1);
        check("arst_wen",    8'(w_total - w_base), 8'd0);
        check("arst_r_error", {7'd0, r_error}, 8'd0);

        // Partial byte before EOP.
        snap();
        start_packet();
        send_byte(8'h80, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_bits(5);
        end_packet();
        check("partial_wen",      8'(w_total - w_base), 8'd1);
        check("partial_r_error",  {7'd0, r_error}, 8'd1);
        check("partial_byte_cnt", byte_cnt, 8'd1);
        check("partial_idle",     {7'd0, cnt_clear}, 8'd1);

        // Eight data bytes: exactly one block-ready pulse.
        snap();
        start_packet();
        send_byte(8'h80, 1'b0);
        for (int i = 0; i < 8; i++)
            send_byte(8'(8'h10 + i), (i == 7));
        check("blk_count",    8'(blk_total - blk_base), 8'd1);
        check("blk_byte_cnt", byte_cnt, 8'd8);
        check("blk_wen",      8'(w_total - w_base), 8'd8);
        check("blk_r_error",  {7'd0, r_error}, 8'd0);
        end_packet();

        // Overflow on the MAX_BYTES=4 instance.
        snap();
        start_packet();
        send_byte(8'h80, 1'b0);
        for (int i = 0; i < 4; i++)
            send_byte(8'(8'h40 + i), 1'b0);
        check("ovf_wen_at4",   8'(w_total_s - w_base_s), 8'd4);
        check("ovf_r_error",   {7'd0, r_error_s}, 8'd1);
        check("ovf_rcving",    {7'd0, rcving_s},  8'd0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h45, 1'b0);
        check("ovf_wen_total", 8'(w_total_s - w_base_s), 8'd4);
        check("ovf_byte_cnt",  byte_cnt_s, 8'd4);
        check("big_byte_cnt",  byte_cnt, 8'd6);
        check("big_r_error",   {7'd0, r_error}, 8'd0);
        end_packet();
        check("ovf_idle",      {7'd0, cnt_clear_s}, 8'd1);
        check("ovf_sticky",    {7'd0, r_error_s},   8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
